// File: rtl/mem_stage_hs.sv
// Purpose : MEM pipeline stage; drives an external data memory over req/ack and
//           registers load/ALU results for writeback (byte/half/word, sign/zero ext).
// Latency : result registered 1 cycle after completion; zero-wait ack gives no bubbles.
// Backpr. : stall is combinational; upstream holds its inputs while stall=1. Output
//           register loads bubbles meanwhile. WAIT aborts with bus_err after MAX_WAIT.
// Ports   : clk/rstb; upstream instruction fields (valid_in, alu_result_in,
//           store_data_in, reg_wr_*_in, mem_rd_en/mem_wr_en/mem_size/mem_signed);
//           stall back to upstream; memory side mem_req/we/addr/wdata/be, mem_ack/rdata;
//           writeback side valid_out, mem_rd_data, alu_result_out, reg_wr_*_out,
//           misalign_err, bus_err.
module mem_stage_hs #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  valid_in,
    input  logic [ADDR_W-1:0]     alu_result_in,
    input  logic [31:0]           store_data_in,
    input  logic [REG_ADDR_W-1:0] reg_wr_addr_in,
    input  logic                  reg_wr_en_in,
    input  logic                  mem_rd_en,
    input  logic                  mem_wr_en,
    input  logic [1:0]            mem_size,
    input  logic                  mem_signed,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  valid_out,
    output logic [31:0]           mem_rd_data,
    output logic [ADDR_W-1:0]     alu_result_out,
    output logic [REG_ADDR_W-1:0] reg_wr_addr_out,
    output logic                  reg_wr_en_out,
    output logic                  misalign_err,
    output logic                  bus_err
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // Byte enables: loads always read the whole word.
    function automatic logic [3:0] enc_be(input logic [1:0] lane, input logic [1:0] size,
                                          input logic is_store);
        logic [3:0] be;
        be = 4'b1111;
        if (is_store) begin
            case (size)
                2'd0:    be = 4'b0001 << lane;
                2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Store data replicated across lanes so the memory only needs to honour be.
    function automatic logic [31:0] enc_wdata(input logic [31:0] d, input logic [1:0] size);
        logic [31:0] w;
        case (size)
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = rdata >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // FSM and captured request fields
    state_t                state_q;
    logic [7:0]            wcnt_q;
    logic [ADDR_W-1:0]     cap_alu_q;
    logic [31:0]           cap_sdata_q;
    logic [1:0]            cap_size_q;
    logic                  cap_signed_q;
    logic                  cap_store_q;
    logic [REG_ADDR_W-1:0] cap_rd_q;
    logic                  cap_rwen_q;

    // Output register
    logic                  valid_q,  valid_d;
    logic [31:0]           rdata_q,  rdata_d;
    logic [ADDR_W-1:0]     alu_q,    alu_d;
    logic [REG_ADDR_W-1:0] rd_q,     rd_d;
    logic                  rwen_q,   rwen_d;
    logic                  mis_q,    mis_d;
    logic                  berr_q,   berr_d;

    // Input decode; reserved size 3 is folded onto word.
    logic       in_access, in_misalign, in_go, in_wait;
    logic [1:0] in_size;

    assign in_size     = (mem_size == 2'd3) ? 2'd2 : mem_size;
    assign in_access   = valid_in & (mem_rd_en | mem_wr_en);
    assign in_misalign = in_access & (((in_size == 2'd1) & alu_result_in[0]) |
                                      ((in_size == 2'd2) & (alu_result_in[1:0] != 2'b00)));
    assign in_go       = in_access & ~in_misalign;
    assign in_wait     = (state_q == S_WAIT);

    // The request in flight: live inputs in IDLE, captured copy in WAIT.
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_sdata;
    logic [1:0]        cur_size;
    logic              cur_signed, cur_store;

    assign cur_addr   = in_wait ? cap_alu_q    : alu_result_in;
    assign cur_sdata  = in_wait ? cap_sdata_q  : store_data_in;
    assign cur_size   = in_wait ? cap_size_q   : in_size;
    assign cur_signed = in_wait ? cap_signed_q : mem_signed;
    assign cur_store  = in_wait ? cap_store_q  : mem_wr_en;

    logic req_active, timeout, stall_int;
    logic [31:0] load_ext;

    assign req_active = in_wait | in_go;
    // An ack on the last permitted cycle still wins over the abort.
    assign timeout    = in_wait & ~mem_ack & (wcnt_q == MAX_WAIT_C);
    assign stall_int  = req_active & ~mem_ack & ~timeout;
    assign load_ext   = extract(mem_rdata, cur_addr[1:0], cur_size, cur_signed);

    // Gated with rstb so reset drops the request and stall without waiting for a clock.
    assign stall     = rstb & stall_int;
    assign mem_req   = rstb & req_active;
    assign mem_we    = cur_store;
    assign mem_addr  = {cur_addr[ADDR_W-1:2], 2'b00};
    assign mem_be    = enc_be(cur_addr[1:0], cur_size, cur_store);
    assign mem_wdata = enc_wdata(cur_sdata, cur_size);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            wcnt_q       <= 8'd0;
            cap_alu_q    <= '0;
            cap_sdata_q  <= '0;
            cap_size_q   <= '0;
            cap_signed_q <= 1'b0;
            cap_store_q  <= 1'b0;
            cap_rd_q     <= '0;
            cap_rwen_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_go & ~mem_ack) begin
                        state_q      <= S_WAIT;
                        wcnt_q       <= 8'd1;
                        cap_alu_q    <= alu_result_in;
                        cap_sdata_q  <= store_data_in;
                        cap_size_q   <= in_size;
                        cap_signed_q <= mem_signed;
                        cap_store_q  <= mem_wr_en;
                        cap_rd_q     <= reg_wr_addr_in;
                        cap_rwen_q   <= reg_wr_en_in;
                    end
                end
                S_WAIT: begin
                    if (mem_ack | timeout) begin
                        state_q <= S_IDLE;
                        wcnt_q  <= 8'd0;
                    end else begin
                        wcnt_q  <= wcnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Result for writeback; a stalled cycle loads a bubble.
    always_comb begin
        valid_d = 1'b0;
        rdata_d = 32'd0;
        alu_d   = '0;
        rd_d    = '0;
        rwen_d  = 1'b0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        if (!stall_int) begin
            if (in_wait) begin
                valid_d = 1'b1;
                alu_d   = cap_alu_q;
                rd_d    = cap_rd_q;
                if (mem_ack) begin
                    rwen_d  = cap_rwen_q;
                    rdata_d = cap_store_q ? 32'd0 : load_ext;
                end else begin
                    berr_d  = 1'b1;
                end
            end else begin
                valid_d = valid_in;
                alu_d   = alu_result_in;
                rd_d    = reg_wr_addr_in;
                rwen_d  = valid_in & reg_wr_en_in & ~in_misalign;
                mis_d   = in_misalign;
                // Reaching here with in_go set implies a zero-wait ack.
                if (in_go & ~mem_wr_en) rdata_d = load_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            alu_q   <= '0;
            rd_q    <= '0;
            rwen_q  <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            rwen_q  <= rwen_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign valid_out       = valid_q;
    assign mem_rd_data     = rdata_q;
    assign alu_result_out  = alu_q;
    assign reg_wr_addr_out = rd_q;
    assign reg_wr_en_out   = rwen_q;
    assign misalign_err    = mis_q;
    assign bus_err         = berr_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Purpose : self-checking bench for mem_stage_hs (table vectors, random vs model, reset cases).
// Latency : drives one instruction per completion, checks results 1 cycle later.
// Backpr. : holds inputs while stall=1; memory ack scripted as a per-instruction delay.
module tb_mem_stage_hs;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rstb;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  reg_wr_addr_in;
    logic        reg_wr_en_in;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        valid_out;
    logic [31:0] mem_rd_data;
    logic [31:0] alu_result_out;
    logic [4:0]  reg_wr_addr_out;
    logic        reg_wr_en_out;
    logic        misalign_err;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_stage_hs #(.ADDR_W(32), .REG_ADDR_W(5), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rstb(rstb), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .reg_wr_addr_in(reg_wr_addr_in),
        .reg_wr_en_in(reg_wr_en_in), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_size(mem_size), .mem_signed(mem_signed), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_out(valid_out),
        .mem_rd_data(mem_rd_data), .alu_result_out(alu_result_out),
        .reg_wr_addr_out(reg_wr_addr_out), .reg_wr_en_out(reg_wr_en_out),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    typedef struct {
        // stimulus
        bit        valid, rd_en, wr_en, rwen, sgn;
        bit [1:0]  size;
        bit [31:0] addr, sdata, rdata;
        bit [4:0]  rd;
        int        delay;   // ack arrives on cycle 'delay' of the instruction
        // expectations
        int        stalls;
        bit        req, vld, wen, mis, bus, we;
        bit [3:0]  be;
        bit [31:0] rdd, wdata, maddr;
    } vec_t;

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input bit valid, input bit rd_en, input bit wr_en,
                                input bit [1:0] size, input bit sgn, input bit [31:0] addr,
                                input bit [31:0] sdata, input bit rwen, input bit [4:0] rd,
                                input int delay, input bit [31:0] rdata);
        vec_t v;
        v = '{default: 0};
        v.valid = valid; v.rd_en = rd_en; v.wr_en = wr_en; v.size = size; v.sgn = sgn;
        v.addr = addr; v.sdata = sdata; v.rwen = rwen; v.rd = rd; v.delay = delay;
        v.rdata = rdata;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input int stalls, input bit req, input bit vld,
                                input bit [31:0] rdd, input bit wen, input bit mis, input bit bus,
                                input bit we, input bit [3:0] be, input bit [31:0] wdata,
                                input bit [31:0] maddr);
        vec_t v;
        v = vi;
        v.stalls = stalls; v.req = req; v.vld = vld; v.rdd = rdd; v.wen = wen; v.mis = mis;
        v.bus = bus; v.we = we; v.be = be; v.wdata = wdata; v.maddr = maddr;
        return v;
    endfunction

    // Reference model: expected behaviour from the access rules, using plain arithmetic.
    function automatic vec_t model(input vec_t vi);
        vec_t v;
        int unsigned lane, sz, b;
        bit access;
        v      = vi;
        access = v.valid && (v.rd_en || v.wr_en);
        lane   = v.addr % 4;
        sz     = (v.size == 3) ? 2 : v.size;
        v.mis  = access && ((sz == 1 && lane % 2 == 1) || (sz == 2 && lane != 0));
        v.req  = access && !v.mis;
        v.bus  = v.req && (v.delay > MAXW);
        v.stalls = !v.req ? 0 : (v.bus ? MAXW : v.delay);
        v.vld  = v.valid;
        v.wen  = v.valid && v.rwen && !v.mis && !v.bus;
        v.we   = v.wr_en;
        v.maddr = v.addr - lane;
        v.rdd  = 0;
        if (v.req && !v.wr_en && !v.bus) begin
            if (sz == 0) begin
                b = (v.rdata >> (8 * lane)) % 256;
                if (v.sgn && b >= 128) b = b - 256;
            end else if (sz == 1) begin
                b = (v.rdata >> (16 * (lane / 2))) % 65536;
                if (v.sgn && b >= 32768) b = b - 65536;
            end else begin
                b = v.rdata;
            end
            v.rdd = b;
        end
        if (!v.wr_en)     v.be = 4'hF;
        else if (sz == 0) v.be = 4'(1 << lane);
        else if (sz == 1) v.be = (lane < 2) ? 4'h3 : 4'hC;
        else              v.be = 4'hF;
        if (sz == 0)      v.wdata = (v.sdata % 256) * 32'h0101_0101;
        else if (sz == 1) v.wdata = (v.sdata % 65536) * 32'h0001_0001;
        else              v.wdata = v.sdata;
        return v;
    endfunction

    task automatic idle();
        valid_in = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_ack = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the completion edge.
    task automatic apply(input vec_t v, input string tag);
        int  k;
        bit  done;
        valid_in = v.valid; alu_result_in = v.addr; store_data_in = v.sdata;
        reg_wr_addr_in = v.rd; reg_wr_en_in = v.rwen; mem_rd_en = v.rd_en;
        mem_wr_en = v.wr_en; mem_size = v.size; mem_signed = v.sgn;
        k = 0;
        done = 0;
        while (!done) begin
            mem_ack   = (k == v.delay);
            mem_rdata = mem_ack ? v.rdata : $urandom;
            #1;
            if (k > 0) begin
                chk($sformatf("%s.bubble_valid_c%0d", tag, k), 32'(valid_out), 32'd0);
                chk($sformatf("%s.bubble_wen_c%0d", tag, k), 32'(reg_wr_en_out), 32'd0);
            end
            chk($sformatf("%s.stall_c%0d", tag, k), 32'(stall), 32'(k < v.stalls));
            if (!v.req) begin
                chk($sformatf("%s.no_req_c%0d", tag, k), 32'(mem_req), 32'd0);
            end else if (!(v.bus && k == v.stalls)) begin
                chk($sformatf("%s.req_c%0d", tag, k), 32'(mem_req), 32'd1);
                chk($sformatf("%s.addr_c%0d", tag, k), mem_addr, v.maddr);
                chk($sformatf("%s.we_c%0d", tag, k), 32'(mem_we), 32'(v.we));
                chk($sformatf("%s.be_c%0d", tag, k), 32'(mem_be), 32'(v.be));
                if (v.we) chk($sformatf("%s.wdata_c%0d", tag, k), mem_wdata, v.wdata);
            end
            if (stall !== 1'b1) done = 1;
            @(posedge clk);
            #1;
            k++;
            if (!done && k > 3 * MAXW + 8) begin
                n_tot++;
                $display("FAIL %s.stall_bound: stall still high after %0d cycles, required release", tag, k);
                done = 1;
            end
        end
        mem_ack = 1'b0;
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(v.vld));
        chk({tag, ".reg_wr_en_out"}, 32'(reg_wr_en_out), 32'(v.wen));
        chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(v.mis));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(v.bus));
        if (v.vld) begin
            chk({tag, ".mem_rd_data"}, mem_rd_data, v.rdd);
            chk({tag, ".alu_result_out"}, alu_result_out, v.addr);
            chk({tag, ".reg_wr_addr_out"}, 32'(reg_wr_addr_out), 32'(v.rd));
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        // Directed vectors, MAX_WAIT = 4.
        tbl.push_back(ex(mk(1,1,0,2,0,32'h10,0,1,3,0,32'hDEAD_BEEF),
                         0,1,1,32'hDEAD_BEEF,1,0,0,0,4'hF,0,32'h10));
        tbl.push_back(ex(mk(1,1,0,0,1,32'h13,0,1,4,3,32'h8011_2233),
                         3,1,1,32'hFFFF_FF80,1,0,0,0,4'hF,0,32'h10));
        tbl.push_back(ex(mk(1,1,0,0,0,32'h13,0,1,4,3,32'h8011_2233),
                         3,1,1,32'h0000_0080,1,0,0,0,4'hF,0,32'h10));
        tbl.push_back(ex(mk(1,0,1,1,0,32'h22,32'h0000_ABCD,0,0,1,0),
                         1,1,1,0,0,0,0,1,4'hC,32'hABCD_ABCD,32'h20));
        tbl.push_back(ex(mk(1,1,0,2,0,32'h06,0,1,5,0,32'h1234_5678),
                         0,0,1,0,0,1,0,0,0,0,0));
        tbl.push_back(ex(mk(1,1,0,2,1,32'h40,0,1,6,9,0),
                         4,1,1,0,0,0,1,0,4'hF,0,32'h40));
        tbl.push_back(ex(mk(1,1,0,1,1,32'h42,0,1,7,0,32'h8001_7FFF),
                         0,1,1,32'hFFFF_8001,1,0,0,0,4'hF,0,32'h40));
        tbl.push_back(ex(mk(1,0,0,2,0,32'h0123_4567,0,1,8,0,0),
                         0,0,1,0,1,0,0,0,0,0,0));
        tbl.push_back(ex(mk(1,1,1,2,0,32'h08,32'h1122_3344,1,9,2,32'hFFFF_FFFF),
                         2,1,1,0,1,0,0,1,4'hF,32'h1122_3344,32'h08));
        tbl.push_back(ex(mk(0,1,0,2,0,32'h10,0,1,10,0,32'h55),
                         0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(ex(mk(1,0,1,0,0,32'h31,32'h0000_005A,0,11,4,0),
                         4,1,1,0,0,0,0,1,4'h2,32'h5A5A_5A5A,32'h30));
        tbl.push_back(ex(mk(1,1,0,3,1,32'h50,0,1,12,1,32'h1234_5678),
                         1,1,1,32'h1234_5678,1,0,0,0,4'hF,0,32'h50));
        tbl.push_back(ex(mk(1,0,1,1,0,32'h21,32'hFFFF,1,13,0,0),
                         0,0,1,0,0,1,0,0,0,0,0));
        tbl.push_back(ex(mk(1,1,0,1,0,32'h60,0,1,14,0,32'hFFFF_8001),
                         0,1,1,32'h0000_8001,1,0,0,0,4'hF,0,32'h60));
        tbl.push_back(ex(mk(1,1,0,0,1,32'h45,0,1,15,0,32'h0000_7F00),
                         0,1,1,32'h0000_007F,1,0,0,0,4'hF,0,32'h44));

        // Reset state, with a live access on the inputs.
        rstb = 1'b0;
        idle();
        valid_in = 1'b1; mem_rd_en = 1'b1; alu_result_in = 32'h10; store_data_in = 0;
        reg_wr_addr_in = 5'd1; reg_wr_en_in = 1'b1; mem_size = 2'd2; mem_signed = 1'b0;
        mem_rdata = 0;
        #3;
        chk("reset.mem_req", 32'(mem_req), 32'd0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.valid_out", 32'(valid_out), 32'd0);
        chk("reset.mem_rd_data", mem_rd_data, 32'd0);
        chk("reset.alu_result_out", alu_result_out, 32'd0);
        chk("reset.reg_wr_en_out", 32'(reg_wr_en_out), 32'd0);
        chk("reset.errs", 32'({misalign_err, bus_err}), 32'd0);
        idle();
        #19;
        rstb = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
            if (i == 5) begin
                // After the timeout: request gone, stage idle, no result.
                idle();
                #1;
                chk("timeout.mem_req_dropped", 32'(mem_req), 32'd0);
                chk("timeout.stall_idle", 32'(stall), 32'd0);
                @(posedge clk);
                #1;
                chk("timeout.idle_valid_out", 32'(valid_out), 32'd0);
            end
        end

        for (int i = 0; i < 200; i++) begin
            v = mk($urandom_range(7, 0) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                   1'($urandom), $urandom, $urandom, 1'($urandom), 5'($urandom),
                   $urandom_range(MAXW + 2, 0), $urandom);
            if ($urandom_range(1, 0) == 1) v.addr[1:0] = 2'b00;
            v = model(v);
            apply(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset clears a live result without a clock edge.
        apply(tbl[0], "pre_rst");
        #2;
        rstb = 1'b0;
        #1;
        chk("arst.valid_out", 32'(valid_out), 32'd0);
        chk("arst.mem_rd_data", mem_rd_data, 32'd0);
        chk("arst.reg_wr_en_out", 32'(reg_wr_en_out), 32'd0);
        chk("arst.reg_wr_addr_out", 32'(reg_wr_addr_out), 32'd0);
        chk("arst.alu_result_out", alu_result_out, 32'd0);
        idle();
        #2;
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of WAIT.
        valid_in = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b0; alu_result_in = 32'h70;
        mem_size = 2'd2; reg_wr_en_in = 1'b1; mem_ack = 1'b0;
        #1;
        chk("mid_wait.stall_c0", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_wait.req_c1", 32'(mem_req), 32'd1);
        chk("mid_wait.stall_c1", 32'(stall), 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_wait.rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_wait.rst_stall", 32'(stall), 32'd0);
        chk("mid_wait.rst_valid_out", 32'(valid_out), 32'd0);
        chk("mid_wait.rst_bus_err", 32'(bus_err), 32'd0);
        idle();
        #2;
        rstb = 1'b1;
        @(posedge clk);
        #1;
        apply(tbl[0], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised MEM pipeline stage that replaces the fixed single-cycle data-SRAM stage.
- Drives an external data memory over a req/ack handshake, so memory latency can vary. Supports byte, halfword and word loads and stores, with sign or zero extension.
- Stalls the upstream pipeline while an access is outstanding. Flags misaligned accesses and bus timeouts.
- Registered results go to writeback.

Parameters:
- ADDR_W, 32, width of the ALU result / byte address.
- REG_ADDR_W, 5, width of the destination register address.
- MAX_WAIT, 15, maximum cycles in WAIT before timeout (1..255).

Ports:
- clk  input  1  clock, rising edge
- rstb  input  1  asynchronous active-low reset
- valid_in  input  1  instruction present in stage
- alu_result_in  input  ADDR_W  effective address / ALU result
- store_data_in  input  32  regB data to store
- reg_wr_addr_in  input  REG_ADDR_W  destination register
- reg_wr_en_in  input  1  instruction writes a register
- mem_rd_en  input  1  load
- mem_wr_en  input  1  store
- mem_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- mem_signed  input  1  sign-extend load
- stall  output  1  combinational; upstream holds all inputs while 1
- mem_req  output  1  memory request
- mem_we  output  1  write request
- mem_addr  output  ADDR_W  word address, low 2 bits forced 0
- mem_wdata  output  32  lane-replicated store data
- mem_be  output  4  byte enables
- mem_ack  input  1  memory completes current request this cycle
- mem_rdata  input  32  read data, valid when mem_ack=1
- valid_out  output  1  registered result valid
- mem_rd_data  output  32  registered, extended load data
- alu_result_out  output  ADDR_W  registered ALU result
- reg_wr_addr_out  output  REG_ADDR_W  registered destination
- reg_wr_en_out  output  1  registered write enable
- misalign_err  output  1  registered, pulses with valid_out
- bus_err  output  1  registered, pulses with valid_out

Behaviour:
- Reset (rstb=0, asynchronous):
  - state = IDLE, wait counter = 0, captured fields = 0.
  - All registered outputs = 0; mem_req = 0, stall = 0.
  - Reset mid-WAIT drops mem_req immediately; the in-flight access is discarded.
- access = valid_in & (mem_rd_en | mem_wr_en). If both enables are set, it is a store; the read is ignored and mem_rd_data = 0.
- Alignment:
  - half requires addr[0] = 0; word requires addr[1:0] = 0.
  - A misaligned access issues no mem_req, completes in 1 cycle, and sets misalign_err = 1, reg_wr_en_out = 0 and mem_rd_data = 0.
- Store encoding (little-endian, lane = addr[1:0]):
  - byte: be = 1<<lane, wdata = {4{d[7:0]}}.
  - half: be = 0011 or 1100, wdata = {2{d[15:0]}}.
  - word: be = 1111, wdata = d.
  - Load: mem_we = 0, be = 1111.
- Load extraction: take mem_rdata bits [8*lane +: 8] (byte) or [16*lane[1] +: 16] (half). Sign-extend if mem_signed = 1, else zero-extend.
- FSM, IDLE:
  - On an aligned access, drive mem_req = 1 with fields taken combinationally from the inputs.
  - If mem_ack = 1 in the same cycle: zero-wait completion, stall = 0.
  - Otherwise: capture fields, go to WAIT, stall = 1, counter = 1.
- FSM, WAIT:
  - mem_req = 1 with the captured fields, held stable; stall = 1 until completion.
  - On mem_ack: complete, stall = 0, go to IDLE.
  - Otherwise, if counter == MAX_WAIT: abort. Complete with bus_err = 1, reg_wr_en_out = 0, mem_rd_data = 0, mem_req dropped, go to IDLE.
  - Otherwise increment counter.
  - mem_ack outside a request is ignored.
- Output register:
  - Loads every cycle stall = 0 with that cycle's result: valid_out = valid_in; a non-memory instruction passes alu_result through with mem_rd_data = 0.
  - While stall = 1 it loads a bubble: valid_out = 0, reg_wr_en_out = 0, error flags = 0.
  - Latency: 1 cycle after completion.
- A completion cycle accepts the next upstream instruction on the following edge. There are no idle gaps when memory acks with zero wait.

Test Plan:
- Word load, addr 0x10, zero-wait ack, rdata 0xDEADBEEF -> next cycle valid_out = 1, mem_rd_data = 0xDEADBEEF, stall never asserted.
- Signed byte load, addr 0x13, rdata 0x80112233, ack after 3 wait cycles -> stall high exactly 3 cycles, mem_addr held at 0x10, then mem_rd_data = 0xFFFFFF80. Repeat with mem_signed = 0 -> 0x00000080.
- Half store, addr 0x22, data 0x0000ABCD -> mem_we = 1, mem_be = 1100, mem_wdata = 0xABCDABCD, mem_addr = 0x20.
- Word load at addr 0x06 -> no mem_req, next cycle misalign_err = 1, reg_wr_en_out = 0, valid_out = 1.
- Load with MAX_WAIT = 4, no ack -> stall high 4 cycles, mem_req drops, next cycle bus_err = 1, reg_wr_en_out = 0; a following access proceeds normally.
- rstb pulsed low during WAIT -> mem_req, stall and all outputs go to 0 asynchronously; after release, state is IDLE and a new zero-wait load completes correctly.
